// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one multi-cycle Booth multiplier among N_REQ requesters,
// with a single backpressured response register tagged by requester index.
module mul_share_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned LAT_SIGNED   = 16,
    parameter int unsigned LAT_UNSIGNED = 17,
    localparam int unsigned ID_W        = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    input  logic [N_REQ-1:0]     req_signed,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [63:0]          resp_data,
    output logic [ID_W-1:0]      resp_id,
    output logic                 mul_start,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    output logic                 mul_is_signed,
    input  logic [63:0]          mul_s,
    output logic                 busy
);

    localparam int unsigned LAT_MAX = (LAT_SIGNED > LAT_UNSIGNED) ? LAT_SIGNED : LAT_UNSIGNED;
    localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StBusy, StComplete} state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   pend_id_q, pend_id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   grant;
    logic              grant_vld;
    logic              mul_start_d, mul_is_signed_d;
    logic [31:0]       mul_a_d, mul_b_d;
    logic              resp_valid_d;
    logic [63:0]       resp_data_d;
    logic [ID_W-1:0]   resp_id_d;

    // First valid requester after the last winner, wrapping around.
    always_comb begin
        int idx;
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            idx = (int'(ptr_q) + k) % int'(N_REQ);
            if (!grant_vld && req_valid[idx]) begin
                grant     = ID_W'(idx);
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == StIdle && grant_vld) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign busy = (state_q != StIdle);

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        pend_id_d       = pend_id_q;
        cnt_d           = cnt_q;
        mul_start_d     = 1'b0;
        mul_a_d         = mul_a;
        mul_b_d         = mul_b;
        mul_is_signed_d = mul_is_signed;
        resp_valid_d    = resp_valid & ~resp_ready;
        resp_data_d     = resp_data;
        resp_id_d       = resp_id;
        case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    mul_a_d         = req_a[32*grant +: 32];
                    mul_b_d         = req_b[32*grant +: 32];
                    mul_is_signed_d = req_signed[grant];
                    pend_id_d       = grant;
                    ptr_d           = grant;
                    mul_start_d     = 1'b1;
                    state_d         = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = mul_is_signed ? CNT_W'(LAT_SIGNED) : CNT_W'(LAT_UNSIGNED);
                state_d = StBusy;
            end
            StBusy: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StComplete;
                end
            end
            StComplete: begin
                // Multiplier is not restarted while waiting, so mul_s holds its product.
                if (!resp_valid || resp_ready) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = mul_s;
                    resp_id_d    = pend_id_q;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            ptr_q         <= ID_W'(N_REQ - 1);
            pend_id_q     <= '0;
            cnt_q         <= '0;
            mul_start     <= 1'b0;
            mul_a         <= '0;
            mul_b         <= '0;
            mul_is_signed <= 1'b0;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            resp_id       <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            pend_id_q     <= pend_id_d;
            cnt_q         <= cnt_d;
            mul_start     <= mul_start_d;
            mul_a         <= mul_a_d;
            mul_b         <= mul_b_d;
            mul_is_signed <= mul_is_signed_d;
            resp_valid    <= resp_valid_d;
            resp_data     <= resp_data_d;
            resp_id       <= resp_id_d;
        end
    end

endmodule
